// File: rtl/huffman_unpack_if.sv
// Bus bundle between the Huffman bit unpacker and its neighbours: the packed-word
// input handshake on one side and the peek/consume window on the other.
interface huffman_unpack_if #(
    parameter int W = 8,
    parameter int C = 4
);
    logic [W-1:0] d_in;
    logic         en_in;
    logic         rdy_in;
    logic [W-1:0] d_out;
    logic         vld_out;
    logic         take;
    logic [C-1:0] w_take;
    logic         drain;
    logic [C+1:0] cnt_out;
    logic         err_out;

    // Unpacker side
    modport slave (
        input  d_in, en_in, take, w_take, drain,
        output rdy_in, d_out, vld_out, cnt_out, err_out
    );

    // Upstream packer / downstream decoder side
    modport master (
        output d_in, en_in, take, w_take, drain,
        input  rdy_in, d_out, vld_out, cnt_out, err_out
    );
endinterface

// File: rtl/huffman_unpack.sv
// Receive-side Huffman bit unpacker. Packed W-bit words are appended to a
// 2W-bit MSB-aligned bit buffer; the top W bits form the peek window for the
// code-table decoder, which consumes a variable number of bits per cycle.
module huffman_unpack #(
    parameter int W = 8,
    parameter int C = 4
) (
    input logic             clk,
    input logic             rst,
    huffman_unpack_if.slave bus
);
    localparam logic [C+1:0] W_CNT = (C+2)'(W);

    // Buffer state: cnt valid bits left-aligned in acc, zeros below them.
    logic [2*W-1:0] acc;
    logic [C+1:0]   cnt;
    logic           err;

    logic [C+1:0]   w_ext;
    logic           rdy;
    logic           vld;
    logic           take_ok;
    logic           load_ok;
    logic           err_next;
    logic [2*W-1:0] acc_shift;
    logic [C+1:0]   cnt_shift;
    logic [2*W-1:0] acc_next;
    logic [C+1:0]   cnt_next;

    // Place a word directly below the pos valid bits already in the buffer.
    // Bits below the valid region are zero, so an OR merges without masking.
    function automatic logic [2*W-1:0] append_word(
        input logic [2*W-1:0] base,
        input logic [W-1:0]   word,
        input logic [C+1:0]   pos
    );
        logic [2*W-1:0] placed;
        placed = {word, {W{1'b0}}} >> pos;
        return base | placed;
    endfunction

    // Flags depend only on registered state (plus drain for the tail window).
    assign rdy   = (cnt <= W_CNT);
    assign vld   = (cnt >= W_CNT) || (bus.drain && (cnt != '0));
    assign w_ext = {2'b00, bus.w_take};

    assign take_ok  = bus.take && vld && (w_ext != '0) && (w_ext <= W_CNT) && (w_ext <= cnt);
    assign load_ok  = bus.en_in && rdy;
    assign err_next = (bus.take && !take_ok) || (bus.en_in && !rdy);

    // Next buffer contents: consume from the head first, then append the new word.
    always_comb begin
        acc_shift = acc;
        cnt_shift = cnt;
        if (take_ok) begin
            acc_shift = acc << bus.w_take;
            cnt_shift = cnt - w_ext;
        end
        acc_next = acc_shift;
        cnt_next = cnt_shift;
        if (load_ok) begin
            acc_next = append_word(acc_shift, bus.d_in, cnt_shift);
            cnt_next = cnt_shift + W_CNT;
        end
    end

    // Register buffer state and the one-cycle error pulse; reset drops all buffered bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            err <= err_next;
        end
    end

    assign bus.d_out   = acc[2*W-1 -: W];
    assign bus.vld_out = vld;
    assign bus.rdy_in  = rdy;
    assign bus.cnt_out = cnt;
    assign bus.err_out = err;
endmodule
